hazard_control_unit: RTL and testbench

Consumer-side control for the ID/EX pipeline register. It reads the decode-stage operands and the ID/EX register outputs (MemRead, rt) and reads branch resolution from EX. From these it generates the PC and IF/ID write enables, the IF/ID flush, and the ID/EX bubble that zeroes the control signals entering the ID/EX register. It holds a small stall FSM and saturating stall/flush statistics counters for the MIPS pipeline.

---
 rtl/hazard_control_unit.sv | 118 +++++++++++
 tb/tb_hazard_control_unit.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_control_unit.sv
// Load-use stall, branch/jump flush and ID/EX bubble control for the MIPS pipeline,
// with saturating stall/flush statistics counters.
module hazard_control_unit #(
  parameter int unsigned STALL_CYCLES = 1,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [4:0]           id_rs,
  input  logic [4:0]           id_rt,
  input  logic                 id_uses_rt,
  input  logic                 id_jump,
  input  logic                 ex_MemRead,
  input  logic [4:0]           ex_rt,
  input  logic                 ex_branch_taken,
  output logic                 pc_write,
  output logic                 ifid_write,
  output logic                 ifid_flush,
  output logic                 idex_bubble,
  output logic                 stalled,
  output logic [CNT_WIDTH-1:0] stall_count,
  output logic [CNT_WIDTH-1:0] flush_count
);

  localparam logic [1:0]           SC_LOAD = 2'(STALL_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic {RUN, STALL} state_t;

  state_t     state, state_next;
  logic [1:0] sc, sc_next;
  logic       lu_hit;
  logic       stall_inc;
  logic       flush_inc;

  // Register 0 is hardwired, so a load targeting it never creates a dependency.
  assign lu_hit = ex_MemRead && (ex_rt != 5'd0) &&
                  ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

  // Next-state and combinational control outputs.
  always_comb begin
    state_next  = state;
    sc_next     = sc;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    stalled     = 1'b0;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;
    if (reset) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      state_next = RUN;
      sc_next    = 2'd0;
    end else begin
      case (state)
        RUN: begin
          if (ex_branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            flush_inc   = 1'b1;
          end else if (lu_hit) begin
            // A jump in ID is simply held here and serviced once the stall ends.
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            stall_inc   = 1'b1;
            if (SC_LOAD != 2'd0) begin
              state_next = STALL;
              sc_next    = SC_LOAD;
            end
          end else if (id_jump) begin
            ifid_flush = 1'b1;
            flush_inc  = 1'b1;
          end
        end
        STALL: begin
          stalled = 1'b1;
          if (ex_branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            flush_inc   = 1'b1;
            state_next  = RUN;
            sc_next     = 2'd0;
          end else begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            stall_inc   = 1'b1;
            sc_next     = sc - 2'd1;
            if (sc == 2'd1) state_next = RUN;
          end
        end
        default: begin
          state_next = RUN;
          sc_next    = 2'd0;
        end
      endcase
    end
  end

  // State register and saturating statistics counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      sc          <= 2'd0;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      state <= state_next;
      sc    <= sc_next;
      if (stall_inc && (stall_count != CNT_MAX)) stall_count <= stall_count + CNT_WIDTH'(1);
      if (flush_inc && (flush_count != CNT_MAX)) flush_count <= flush_count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Scoreboard bench: three configurations driven in lockstep and compared against a
// cycle-level reference model of the hazard rules.
module tb_hazard_control_unit;

  typedef struct packed {
    logic        chk;
    logic [4:0]  ctl;   // {pc_write, ifid_write, ifid_flush, idex_bubble, stalled}
    logic [15:0] sc;
    logic [15:0] fc;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] id_rs = '0, id_rt = '0, ex_rt = '0;
  logic       id_uses_rt = 1'b0, id_jump = 1'b0, ex_MemRead = 1'b0, ex_branch_taken = 1'b0;

  logic        pw0, iw0, fl0, bb0, st0;
  logic        pw1, iw1, fl1, bb1, st1;
  logic        pw2, iw2, fl2, bb2, st2;
  logic [15:0] scnt0, fcnt0, scnt1, fcnt1;
  logic [3:0]  scnt2, fcnt2;

  int checks = 0;
  int fails  = 0;

  exp_t q0[$], q1[$], q2[$];

  int stall_len[3] = '{1, 3, 2};
  int cnt_max[3]   = '{65535, 65535, 15};
  int rem[3];
  int m_sc[3];
  int m_fc[3];
  bit known = 1'b0;

  always #5 clk = ~clk;

  hazard_control_unit #(.STALL_CYCLES(1), .CNT_WIDTH(16)) u0 (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_jump(id_jump), .ex_MemRead(ex_MemRead), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
    .pc_write(pw0), .ifid_write(iw0), .ifid_flush(fl0), .idex_bubble(bb0), .stalled(st0),
    .stall_count(scnt0), .flush_count(fcnt0));

  hazard_control_unit #(.STALL_CYCLES(3), .CNT_WIDTH(16)) u1 (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_jump(id_jump), .ex_MemRead(ex_MemRead), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
    .pc_write(pw1), .ifid_write(iw1), .ifid_flush(fl1), .idex_bubble(bb1), .stalled(st1),
    .stall_count(scnt1), .flush_count(fcnt1));

  hazard_control_unit #(.STALL_CYCLES(2), .CNT_WIDTH(4)) u2 (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_jump(id_jump), .ex_MemRead(ex_MemRead), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
    .pc_write(pw2), .ifid_write(iw2), .ifid_flush(fl2), .idex_bubble(bb2), .stalled(st2),
    .stall_count(scnt2), .flush_count(fcnt2));

  // Reference model: outputs for the current cycle, then advance to the next cycle.
  function automatic exp_t model_step(input int i);
    exp_t e;
    bit   lu;
    e.chk = known;
    e.sc  = 16'(m_sc[i]);
    e.fc  = 16'(m_fc[i]);
    lu = ex_MemRead && (ex_rt != 0) && (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt));
    if (reset) begin
      e.ctl = 5'b00000;
      rem[i] = 0; m_sc[i] = 0; m_fc[i] = 0;
    end else if (ex_branch_taken) begin
      e.ctl = {4'b1111, rem[i] > 0};
      rem[i] = 0;
      m_fc[i] = (m_fc[i] + 1 > cnt_max[i]) ? cnt_max[i] : m_fc[i] + 1;
    end else if (rem[i] > 0) begin
      e.ctl = 5'b00011;
      rem[i] = rem[i] - 1;
      m_sc[i] = (m_sc[i] + 1 > cnt_max[i]) ? cnt_max[i] : m_sc[i] + 1;
    end else if (lu) begin
      e.ctl = 5'b00010;
      rem[i] = stall_len[i] - 1;
      m_sc[i] = (m_sc[i] + 1 > cnt_max[i]) ? cnt_max[i] : m_sc[i] + 1;
    end else if (id_jump) begin
      e.ctl = 5'b11100;
      m_fc[i] = (m_fc[i] + 1 > cnt_max[i]) ? cnt_max[i] : m_fc[i] + 1;
    end else begin
      e.ctl = 5'b11000;
    end
    return e;
  endfunction

  task automatic drive(input bit rst, input int rs, input int rt, input bit uses,
                       input bit jmp, input bit mr, input int ert, input bit br);
    @(posedge clk);
    #1;
    reset = rst; id_rs = 5'(rs); id_rt = 5'(rt); id_uses_rt = uses; id_jump = jmp;
    ex_MemRead = mr; ex_rt = 5'(ert); ex_branch_taken = br;
    q0.push_back(model_step(0));
    q1.push_back(model_step(1));
    q2.push_back(model_step(2));
    if (rst) known = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(0, 1, 2, 0, 0, 0, 0, 0);
  endtask

  task automatic chk(input string nm, input exp_t e, input logic [4:0] ctl,
                     input logic [15:0] sc, input logic [15:0] fc);
    checks++;
    if (ctl !== e.ctl) begin
      fails++;
      $display("FAIL %s ctl t=%0t got=%b exp=%b", nm, $time, ctl, e.ctl);
    end
    if (e.chk) begin
      checks++;
      if (sc !== e.sc) begin
        fails++;
        $display("FAIL %s stall_count t=%0t got=%0d exp=%0d", nm, $time, sc, e.sc);
      end
      checks++;
      if (fc !== e.fc) begin
        fails++;
        $display("FAIL %s flush_count t=%0t got=%0d exp=%0d", nm, $time, fc, e.fc);
      end
    end
  endtask

  // Monitor: outputs are valid every cycle, sampled mid-cycle on the falling edge.
  always @(negedge clk) begin
    if (q0.size() > 0) chk("sc1", q0.pop_front(), {pw0, iw0, fl0, bb0, st0}, scnt0, fcnt0);
    if (q1.size() > 0) chk("sc3", q1.pop_front(), {pw1, iw1, fl1, bb1, st1}, scnt1, fcnt1);
    if (q2.size() > 0) chk("sc2w4", q2.pop_front(), {pw2, iw2, fl2, bb2, st2},
                           {12'd0, scnt2}, {12'd0, fcnt2});
  end

  initial begin
    // Reset with a pending hazard, then release with the hazard still present.
    drive(1, 5, 0, 0, 0, 1, 5, 0);
    drive(1, 5, 0, 0, 0, 1, 5, 0);
    drive(0, 5, 0, 0, 0, 1, 5, 0);
    idle(4);
    // Load-use on rt with and without id_uses_rt.
    drive(0, 1, 8, 1, 0, 1, 8, 0);
    idle(3);
    drive(0, 1, 8, 0, 0, 1, 8, 0);
    // Zero register never hazards.
    drive(0, 0, 0, 1, 0, 1, 0, 0);
    // Load-use on rs.
    drive(0, 9, 3, 0, 0, 1, 9, 0);
    idle(4);
    // Branch beats load-use and jump.
    drive(0, 9, 9, 1, 1, 1, 9, 1);
    idle(2);
    // Deferred jump: jump held in ID through the stall.
    drive(0, 4, 0, 0, 1, 1, 4, 0);
    drive(0, 4, 0, 0, 1, 0, 4, 0);
    drive(0, 4, 0, 0, 1, 0, 4, 0);
    drive(0, 4, 0, 0, 1, 0, 4, 0);
    idle(2);
    // Reset in the second stall cycle, then a branch arriving during a stall.
    drive(0, 7, 0, 0, 0, 1, 7, 0);
    drive(1, 7, 0, 0, 0, 0, 7, 0);
    idle(3);
    drive(0, 7, 0, 0, 0, 1, 7, 0);
    drive(0, 7, 0, 0, 0, 0, 7, 1);
    idle(3);
    // Counter saturation on the 4-bit configuration.
    for (int k = 0; k < 20; k++) drive(0, 1, 2, 0, 1, 0, 0, 0);
    for (int k = 0; k < 12; k++) drive(0, 3, 3, 1, 0, 1, 3, 0);
    idle(2);
    // Randomised traffic with small register numbers to make hazards frequent.
    for (int k = 0; k < 1500; k++)
      drive($urandom_range(99) < 2, $urandom_range(3), $urandom_range(3), $urandom_range(1),
            $urandom_range(99) < 15, $urandom_range(99) < 50, $urandom_range(3),
            $urandom_range(99) < 10);
    idle(2);
    repeat (3) @(negedge clk);
    checks++;
    if (q0.size() + q1.size() + q2.size() != 0) begin
      fails++;
      $display("FAIL drain got=%0d pending exp=0", q0.size() + q1.size() + q2.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
